// File: rtl/ntt_stream_io.sv
// ntt_stream_io
//   Streaming I/O stage around the radix-4 NTT/INTT core.
//   Load:   a serial stream of N coefficients is packed four per row into the
//           two dual-port coefficient BRAMs (lane i[1:0], row i>>2).
//   Kick:   one-cycle ntt_start, then wait for the ntt_done pulse.
//   Unload: rows are read back and streamed out with valid/ready
//           backpressure; out_last marks the final word.
//   io_own tells the top level to route this block's BRAM signals.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   start / busy                  job start pulse, job-in-progress flag
//   in_data/in_valid/in_ready     coefficient input stream
//   out_data/out_valid/out_ready/out_last   result stream
//   ntt_start / ntt_done          core handshake
//   io_own                        BRAM port ownership for the top-level mux
//   bram_addr, bram_we            shared row address / write enable
//   bram_din0..3, bram_dout0..3   lanes: bram0.a, bram0.b, bram1.a, bram1.b
//   range_err                     sticky "input >= Q" flag (optional)
//
// Optional feature: define NTT_IO_RANGE_CHECK_EN to add the range_err port
// and its comparator.
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start, BRAMs owned by the core side
// LOAD  | accepting input words, writing a row after every 4th word
// KICK  | ntt_start pulse visible
// WAIT  | waiting for ntt_done
// RD    | row address presented to the BRAMs
// CAP   | BRAM read data captured into the output buffer
// SEND  | four buffered words streamed out under backpressure

module ntt_stream_io #(
    parameter int          N  = 256,
    parameter int          DW = 32,
    parameter int          AW = 8,
    parameter logic [31:0] Q  = 32'd8380417
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          ntt_start,
    input  logic          ntt_done,
    output logic          io_own,
    output logic [AW-1:0] bram_addr,
    output logic          bram_we,
    output logic [DW-1:0] bram_din0,
    output logic [DW-1:0] bram_din1,
    output logic [DW-1:0] bram_din2,
    output logic [DW-1:0] bram_din3,
    input  logic [DW-1:0] bram_dout0,
    input  logic [DW-1:0] bram_dout1,
    input  logic [DW-1:0] bram_dout2,
    input  logic [DW-1:0] bram_dout3
`ifdef NTT_IO_RANGE_CHECK_EN
    ,
    output logic          range_err
`endif
);

    generate
        if ((N % 4) != 0 || (N / 4) > (1 << AW) || Q == 32'd0) begin : g_param_check
            $error("ntt_stream_io: N must be a multiple of 4, 2^AW >= N/4, Q nonzero");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KICK,
        S_WAIT,
        S_RD,
        S_CAP,
        S_SEND
    } state_t;

    // cnt runs to N (one past the last word) so the write cycle of the final
    // row is recognisable without a separate flag.
    localparam int              CW       = $clog2(N) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0]   CNT_END  = CW'(N);
    localparam logic [AW-1:0]   ROW_LAST = AW'(N / 4 - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [AW-1:0] row;
    logic [1:0]    lane;
    logic [DW-1:0] in_buf  [4];
    logic [DW-1:0] out_buf [4];

    logic in_fire;
    logic out_fire;

    // in_ready is only ever set while in LOAD, so no state qualifier needed.
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            row       <= '0;
            lane      <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            ntt_start <= 1'b0;
            io_own    <= 1'b0;
            bram_addr <= '0;
            bram_we   <= 1'b0;
            bram_din0 <= '0;
            bram_din1 <= '0;
            bram_din2 <= '0;
            bram_din3 <= '0;
            for (int k = 0; k < 4; k++) begin
                in_buf[k]  <= '0;
                out_buf[k] <= '0;
            end
`ifdef NTT_IO_RANGE_CHECK_EN
            range_err <= 1'b0;
`endif
        end else begin
            bram_we   <= 1'b0;
            ntt_start <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LOAD;
                        cnt      <= '0;
                        row      <= '0;
                        lane     <= '0;
                        busy     <= 1'b1;
                        io_own   <= 1'b1;
                        in_ready <= 1'b1;
`ifdef NTT_IO_RANGE_CHECK_EN
                        range_err <= 1'b0;
`endif
                    end
                end

                S_LOAD: begin
                    if (in_fire) begin
                        cnt                <= cnt + CW'(1);
                        in_buf[cnt[1:0]]   <= in_data;
                        // Lane 3 completes a row: lane 3 comes straight from
                        // the input so the write needs no extra cycle.
                        if (cnt[1:0] == 2'd3) begin
                            bram_din0 <= in_buf[0];
                            bram_din1 <= in_buf[1];
                            bram_din2 <= in_buf[2];
                            bram_din3 <= in_data;
                            bram_addr <= AW'(cnt >> 2);
                            bram_we   <= 1'b1;
                        end
                        if (cnt == CNT_LAST) begin
                            in_ready <= 1'b0;
                        end
`ifdef NTT_IO_RANGE_CHECK_EN
                        if ({32'd0, in_data} >= {{DW{1'b0}}, Q}) begin
                            range_err <= 1'b1;
                        end
`endif
                    end
                    // cnt == N only during the final row's write cycle.
                    if (cnt == CNT_END) begin
                        state     <= S_KICK;
                        io_own    <= 1'b0;
                        ntt_start <= 1'b1;
                    end
                end

                S_KICK: begin
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (ntt_done) begin
                        state     <= S_RD;
                        io_own    <= 1'b1;
                        row       <= '0;
                        bram_addr <= '0;
                    end
                end

                S_RD: begin
                    state <= S_CAP;
                end

                S_CAP: begin
                    out_buf[0] <= bram_dout0;
                    out_buf[1] <= bram_dout1;
                    out_buf[2] <= bram_dout2;
                    out_buf[3] <= bram_dout3;
                    out_data   <= bram_dout0;
                    out_valid  <= 1'b1;
                    out_last   <= 1'b0;
                    lane       <= '0;
                    state      <= S_SEND;
                end

                S_SEND: begin
                    if (out_fire) begin
                        if (lane == 2'd3) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            if (row == ROW_LAST) begin
                                state  <= S_IDLE;
                                busy   <= 1'b0;
                                io_own <= 1'b0;
                            end else begin
                                row       <= row + AW'(1);
                                bram_addr <= row + AW'(1);
                                state     <= S_RD;
                            end
                        end else begin
                            lane     <= lane + 2'd1;
                            out_data <= out_buf[lane + 2'd1];
                            out_last <= (lane == 2'd2) && (row == ROW_LAST);
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ntt_stream_io.md
# ntt_stream_io

Streaming I/O stage around the radix-4 NTT/INTT core. It accepts a serial stream of N coefficients and scatters them four per cycle into the two dual-port coefficient BRAMs. It then pulses the core's `start`, waits for `done`, and streams the N results back out with valid/ready backpressure. It owns the BRAM ports only during load and unload; the top level muxes BRAM ports on `io_own`.

## Interface
Parameters:
- `N`, 256, coefficients per polynomial; multiple of 4.
- `DW`, 32, coefficient width.
- `AW`, 8, BRAM address width; must satisfy 2^AW ≥ N/4.
- `Q`, 32'd8380417, modulus; used only by the range check.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins a job from IDLE; ignored otherwise.
- `busy` out 1: high from the cycle after accepted `start` until the final output handshake completes.
- `in_data` in DW, `in_valid` in 1, `in_ready` out 1: coefficient input stream.
- `out_data` out DW, `out_valid` out 1, `out_ready` in 1, `out_last` out 1: result stream; `out_last` marks the final word.
- `ntt_start` out 1, `ntt_done` in 1: core handshake; `ntt_done` is sampled as a pulse.
- `io_own` out 1: when 1, the top routes this block's BRAM signals to the BRAMs.
- `bram_addr` out AW: row address, shared by all four ports.
- `bram_we` out 1: shared write enable.
- `bram_din0`..`bram_din3` out DW: lanes 0..3, mapped as bram0.a, bram0.b, bram1.a, bram1.b.
- `bram_dout0`..`bram_dout3` in DW: same lane mapping; 1-cycle read latency.
- `range_err` out 1: sticky flag; exists only with the macro defined.

## Operation
- Layout: coefficient i goes to lane i[1:0], row i>>2.
- FSM states: IDLE → LOAD → KICK → WAIT → RD → CAP → SEND → (RD | IDLE).
- IDLE:
  - `in_ready`=0, `io_own`=0.
  - `start` moves the FSM to LOAD and clears the counters.
- LOAD:
  - `io_own`=1, `in_ready`=1.
  - Each handshake stores `in_data` into lane `cnt[1:0]` and increments `cnt`.
  - On the lane-3 handshake, all four lanes are registered onto `bram_din0..3` with `bram_addr`=row. `bram_we`=1 for exactly the next cycle.
  - `in_ready` stays 1 through that write cycle, so full-rate input is supported.
  - After the write of row N/4−1, go to KICK.
- KICK: `io_own`=0; `ntt_start`=1 for one cycle; go to WAIT.
- WAIT: hold until `ntt_done`=1. `ntt_done` seen in any other state is ignored.
- RD: `io_own`=1, `bram_we`=0, `bram_addr`=row; row counter starts at 0.
- CAP: register `bram_dout0..3` into the 4-word output buffer.
- SEND:
  - Present lanes 0..3 in order with `out_valid`=1.
  - Advance a lane only on `out_valid && out_ready`; hold `out_data` stable while stalled.
  - After lane 3 is accepted: go to RD with the next row, or to IDLE after row N/4−1.
- `out_last`=1 only together with lane 3 of row N/4−1.
- `start` while `busy` is ignored.
- Input words arriving in any state other than LOAD are not accepted (`in_ready`=0).

## Timing
- Reset: every output is 0, FSM is IDLE, counters and buffers are cleared. `range_err`=0.
- Reset mid-job: the job is abandoned and partial data is discarded. `io_own` drops in the cycle after `rst` is sampled.
- Load: N handshakes minimum. `ntt_start` fires 2 cycles after the final input handshake (write cycle, then KICK).
- Unload:
  - Throughput is 4 words per 6 cycles with no backpressure.
  - First `out_valid` is 3 cycles after `ntt_done` is sampled (RD, CAP, SEND).
- `busy` falls the cycle after the `out_last` handshake. A new `start` is accepted in that same cycle.

## Configuration
- Macro `NTT_IO_RANGE_CHECK_EN`.
- Defined: every accepted `in_data` ≥ Q sets `range_err`, which holds until `rst` or the next accepted `start`. The data is still written unchanged.
- Undefined: the `range_err` port and its comparator are absent.

## Test plan
- N=256, ramp input 0..255 at full rate → 64 `bram_we` pulses; row 5 carries din0..3 = 20,21,22,23; one `ntt_start` pulse 2 cycles after the last handshake.
- In LOAD, drop `in_valid` randomly (50%) → identical BRAM writes; `bram_we` only after every 4th accepted word.
- `ntt_done` pulse, BRAM model returning row*4+lane, `out_ready`=1 → outputs 0..255 in order; `out_last` only on 255; first `out_valid` 3 cycles after `ntt_done`.
- `out_ready` toggled 1-on/3-off → `out_data` held while stalled; no loss or duplication.
- `rst` asserted mid-LOAD after 37 words, then a new job → first write row 0 holds the new words 0..3; `io_own`=0 right after reset.
- `NTT_IO_RANGE_CHECK_EN` defined, word 17 = Q → `range_err` rises the cycle after that handshake, stays high, and clears on the next `start`.
